// File: rtl/arrozYleche_pkg.sv
// arrozYleche_pkg: address map, region select and register offsets shared by the memory responder
package arrozYleche_pkg;

    localparam logic [15:0] INSTR_BASE = 16'h0000;
    localparam logic [15:0] INTC_BASE  = 16'h5FFF;
    localparam logic [15:0] DSTK_BASE  = 16'h6FFE;
    localparam logic [15:0] IO_BASE    = 16'hCFFD;

    typedef enum logic [1:0] {
        RGN_RAM,
        RGN_INTC,
        RGN_IO
    } rgn_t;

    localparam int INTC_PEND = 0;
    localparam int INTC_MASK = 1;
    localparam int IO_LEDS   = 0;
    localparam int IO_SW     = 1;
    localparam int IO_TCNT   = 2;
    localparam int IO_TCMP   = 3;

    localparam int PEND_TMR = 0;
    localparam int PEND_EXT = 1;

endpackage

// File: rtl/mem_io_responder_sync2.sv
// sync2: two-flop synchronizer for asynchronous board inputs
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // two register stages to settle metastability before use
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: decodes CPU accesses to RAM, interrupt-control and IO registers with 1-cycle read latency
module mem_io_responder
    import arrozYleche_pkg::*;
#(
    parameter int               WIDTH             = 16,
    parameter logic [WIDTH-1:0] INSTRUCTION_MEM   = WIDTH'(INSTR_BASE),
    parameter logic [WIDTH-1:0] INTERRUPT_CONTROL = WIDTH'(INTC_BASE),
    parameter logic [WIDTH-1:0] DATA_STACK        = WIDTH'(DSTK_BASE),
    parameter logic [WIDTH-1:0] IO_MEM            = WIDTH'(IO_BASE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] memOut,
    input  logic             memwrite_a,
    input  logic             memwrite_b,
    output logic [WIDTH-1:0] memdata,
    output logic [WIDTH-1:0] ram_adr,
    output logic [WIDTH-1:0] ram_wdata,
    output logic             ram_we,
    input  logic [WIDTH-1:0] ram_rdata,
    input  logic [WIDTH-1:0] switches,
    input  logic             ext_irq,
    output logic [WIDTH-1:0] leds,
    output logic             irq
);

    logic             wr;
    logic             intc_wr;
    logic             io_wr;
    logic             match;
    logic             ext_s;
    logic             ext_d;
    logic [1:0]       pend;
    logic [1:0]       mask;
    logic [1:0]       set;
    logic [1:0]       clr;
    logic [WIDTH-1:0] off;
    logic [WIDTH-1:0] rd_val;
    logic [WIDTH-1:0] rd_q;
    logic [WIDTH-1:0] tcnt;
    logic [WIDTH-1:0] tcmp;
    logic [WIDTH-1:0] sw_s;
    rgn_t             rgn;
    rgn_t             sel_q;

    sync2 #(.W(WIDTH)) u_sw  (.clk(clk), .reset(reset), .d(switches), .q(sw_s));
    sync2 #(.W(1))     u_ext (.clk(clk), .reset(reset), .d(ext_irq),  .q(ext_s));

    assign ram_adr   = adr;
    assign ram_wdata = memOut;
    assign ram_we    = wr && (rgn == RGN_RAM);
    assign memdata   = !reset ? '0 : (sel_q == RGN_RAM) ? ram_rdata : rd_q;

    // address decode, register read mux and interrupt set/clear terms
    always_comb begin
        wr      = memwrite_a | memwrite_b;
        rgn     = (adr < INTERRUPT_CONTROL) ? RGN_RAM :
                  (adr < DATA_STACK)        ? RGN_INTC :
                  (adr < IO_MEM)            ? RGN_RAM : RGN_IO;
        off     = adr - ((rgn == RGN_INTC) ? INTERRUPT_CONTROL :
                         (rgn == RGN_IO)   ? IO_MEM : INSTRUCTION_MEM);
        intc_wr = wr && (rgn == RGN_INTC);
        io_wr   = wr && (rgn == RGN_IO);
        match   = (tcmp != '0) && (tcnt == tcmp);
        clr     = (intc_wr && off == WIDTH'(INTC_PEND)) ? memOut[1:0] : 2'b00;
        set     = 2'b00;
        set[PEND_TMR] = match;
        set[PEND_EXT] = ext_s & ~ext_d;
        rd_val  = (rgn == RGN_INTC) ?
                      ((off == WIDTH'(INTC_PEND)) ? {{(WIDTH-2){1'b0}}, pend} :
                       (off == WIDTH'(INTC_MASK)) ? {{(WIDTH-2){1'b0}}, mask} : '0) :
                  (rgn == RGN_IO) ?
                      ((off == WIDTH'(IO_LEDS)) ? leds :
                       (off == WIDTH'(IO_SW))   ? sw_s :
                       (off == WIDTH'(IO_TCNT)) ? tcnt :
                       (off == WIDTH'(IO_TCMP)) ? tcmp : '0) : '0;
    end

    // read pipeline, peripheral registers, timer and interrupt state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q <= RGN_RAM;
            rd_q  <= '0;
            ext_d <= 1'b0;
            pend  <= 2'b00;
            mask  <= 2'b00;
            irq   <= 1'b0;
            leds  <= '0;
            tcnt  <= '0;
            tcmp  <= '0;
        end else begin
            sel_q <= rgn;
            rd_q  <= rd_val;
            ext_d <= ext_s;
            pend  <= (pend & ~clr) | set;
            irq   <= |(pend & mask);
            tcnt  <= (match || (io_wr && off == WIDTH'(IO_TCNT))) ? '0 : tcnt + WIDTH'(1);
            if (intc_wr && off == WIDTH'(INTC_MASK))
                mask <= memOut[1:0];
            if (io_wr && off == WIDTH'(IO_LEDS))
                leds <= memOut;
            if (io_wr && off == WIDTH'(IO_TCMP))
                tcmp <= memOut;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed stimulus against a cycle-level model of the responder's address map and interrupts
module tb_mem_io_responder;

    logic        clk = 0;
    logic        reset = 1;
    logic [15:0] adr = 0;
    logic [15:0] memOut = 0;
    logic        memwrite_a = 0;
    logic        memwrite_b = 0;
    logic [15:0] ram_rdata = 0;
    logic [15:0] switches = 0;
    logic        ext_irq = 0;
    logic [15:0] memdata;
    logic [15:0] ram_adr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] leds;
    logic        irq;

    mem_io_responder dut (
        .clk(clk), .reset(reset), .adr(adr), .memOut(memOut),
        .memwrite_a(memwrite_a), .memwrite_b(memwrite_b), .memdata(memdata),
        .ram_adr(ram_adr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .switches(switches), .ext_irq(ext_irq),
        .leds(leds), .irq(irq)
    );

    always #10 clk = ~clk;

    int nchk = 0;
    int npass = 0;

    bit [15:0] ram [0:65535];

    logic [15:0] m_leds, m_tcnt, m_tcmp, m_md;
    logic [1:0]  m_pend, m_mask;
    logic        m_irq;
    logic [15:0] sw_h [0:1];
    logic        ext_h [0:2];

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // 0 = RAM, 1 = interrupt control, 2 = IO
    function automatic int region(input logic [15:0] a);
        if (a < 16'h5FFF) return 0;
        if (a < 16'h6FFE) return 1;
        if (a < 16'hCFFD) return 0;
        return 2;
    endfunction

    function automatic logic [15:0] reg_read(input logic [15:0] a);
        int r;
        logic [15:0] o;
        r = region(a);
        if (r == 1) begin
            o = a - 16'h5FFF;
            return (o == 0) ? {14'b0, m_pend} : (o == 1) ? {14'b0, m_mask} : 16'h0;
        end
        if (r == 2) begin
            o = a - 16'hCFFD;
            return (o == 0) ? m_leds : (o == 1) ? sw_h[1] : (o == 2) ? m_tcnt : (o == 3) ? m_tcmp : 16'h0;
        end
        return 16'h0;
    endfunction

    // model step, external RAM behaviour and per-cycle comparison
    always @(posedge clk) begin
        logic w;
        int r;
        logic [15:0] o;
        logic hit;
        logic [1:0] clr, setv;
        if (!reset) begin
            m_leds = 0; m_tcnt = 0; m_tcmp = 0; m_md = 0;
            m_pend = 0; m_mask = 0; m_irq = 0;
            sw_h[0] = 0; sw_h[1] = 0;
            ext_h[0] = 0; ext_h[1] = 0; ext_h[2] = 0;
        end else begin
            w = memwrite_a | memwrite_b;
            r = region(adr);
            o = adr - ((r == 1) ? 16'h5FFF : (r == 2) ? 16'hCFFD : 16'h0000);
            m_md = (r == 0) ? ram[adr] : reg_read(adr);
            hit = (m_tcmp != 0) && (m_tcnt == m_tcmp);
            clr = (w && r == 1 && o == 0) ? memOut[1:0] : 2'b00;
            setv = {ext_h[1] & ~ext_h[2], hit};
            m_irq = |(m_pend & m_mask);
            m_pend = (m_pend & ~clr) | setv;
            if (w && r == 1 && o == 1) m_mask = memOut[1:0];
            if (w && r == 2 && o == 0) m_leds = memOut;
            m_tcnt = (hit || (w && r == 2 && o == 2)) ? 16'h0 : m_tcnt + 16'd1;
            if (w && r == 2 && o == 3) m_tcmp = memOut;
            sw_h[1] = sw_h[0]; sw_h[0] = switches;
            ext_h[2] = ext_h[1]; ext_h[1] = ext_h[0]; ext_h[0] = ext_irq;
        end
        ram_rdata <= ram[ram_adr];
        if (ram_we) ram[ram_adr] = ram_wdata;
        #1;
        check("memdata", memdata, m_md);
        check("leds", leds, m_leds);
        check("irq", 16'(irq), 16'(m_irq));
        check("ram_we", 16'(ram_we), 16'((memwrite_a | memwrite_b) && region(adr) == 0));
        check("ram_adr", ram_adr, adr);
        check("ram_wdata", ram_wdata, memOut);
    end

    task automatic wr_op(input logic [15:0] a, input logic [15:0] d, input logic use_b);
        adr = a; memOut = d;
        memwrite_a = !use_b; memwrite_b = use_b;
        @(negedge clk);
        memwrite_a = 0; memwrite_b = 0;
    endtask

    task automatic rd_op(input string nm, input logic [15:0] a, input logic [15:0] e);
        adr = a; memwrite_a = 0; memwrite_b = 0;
        @(negedge clk);
        check(nm, memdata, e);
    endtask

    initial begin
        ram[16'h0010] = 16'hBEEF;
        ram[16'h5FFE] = 16'h1111;
        ram[16'h6FFE] = 16'h2222;
        #2 reset = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);

        wr_op(16'hCFFD, 16'hAAAA, 0);
        check("leds_set", leds, 16'hAAAA);
        adr = 16'hCFFD; memOut = 16'h5555; memwrite_a = 1;
        #3 reset = 0;
        #1;
        check("rst_leds", leds, 16'h0000);
        check("rst_memdata", memdata, 16'h0000);
        check("rst_irq", 16'(irq), 16'h0);
        @(negedge clk);
        memwrite_a = 0;
        @(negedge clk);
        reset = 1;
        @(negedge clk);

        adr = 16'h7000; memOut = 16'h1234; memwrite_b = 1;
        #1;
        check("pt_ram_we", 16'(ram_we), 16'h1);
        check("pt_ram_adr", ram_adr, 16'h7000);
        @(negedge clk);
        memwrite_b = 0;
        rd_op("ram_rd_7000", 16'h7000, 16'h1234);
        rd_op("ram_rd_0010", 16'h0010, 16'hBEEF);

        wr_op(16'hCFFD, 16'h5A5A, 1);
        rd_op("edge_5FFE", 16'h5FFE, 16'h1111);
        rd_op("edge_5FFF", 16'h5FFF, 16'h0000);
        rd_op("edge_6FFE", 16'h6FFE, 16'h2222);
        rd_op("edge_CFFD", 16'hCFFD, 16'h5A5A);
        rd_op("edge_FFFF", 16'hFFFF, 16'h0000);

        switches = 16'hC3C3;
        repeat (3) @(negedge clk);
        rd_op("sw_read", 16'hCFFE, 16'hC3C3);

        wr_op(16'h6000, 16'h0001, 0);
        wr_op(16'hCFFF, 16'h0000, 0);
        wr_op(16'hD000, 16'h0005, 0);
        for (int i = 0; i < 30 && !irq; i++) @(negedge clk);
        check("timer_irq", 16'(irq), 16'h1);
        rd_op("tcmp_read", 16'hD000, 16'h0005);

        for (int i = 0; i < 20 && m_tcnt != 16'd5; i++) @(negedge clk);
        check("coll_wait_tcnt", m_tcnt, 16'd5);
        wr_op(16'h5FFF, 16'h0001, 0);
        rd_op("coll_pend", 16'h5FFF, 16'h0001);

        wr_op(16'hD000, 16'h0000, 0);
        wr_op(16'h5FFF, 16'h0001, 0);
        @(negedge clk);
        check("timer_irq_clr", 16'(irq), 16'h0);

        wr_op(16'h6000, 16'h0002, 0);
        ext_irq = 1;
        for (int i = 0; i < 6 && !irq; i++) @(negedge clk);
        check("ext_irq", 16'(irq), 16'h1);
        wr_op(16'h5FFF, 16'h0002, 1);
        repeat (8) @(negedge clk);
        check("ext_noretrig", 16'(irq), 16'h0);
        rd_op("ext_pend", 16'h5FFF, 16'h0000);
        ext_irq = 0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
